sad_search_ctrl: RTL and testbench

Sequencer for the 16-lane absolute-difference datapath used in block-matching motion search. On each cycle it issues one block row at one candidate offset to the frame/window row buffers that feed the subtractor array. It accumulates the returned per-row SAD into a per-candidate SAD, tracks the minimum, and reports the best offset with a start/done handshake.

---
 rtl/sad_search_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl
// ----------------
// Sequencer for the 16-lane absolute-difference datapath used in block-matching
// motion search. Each cycle in ISSUE it addresses one block row at one candidate
// offset (row fastest, then x, then y). It accumulates the per-row SAD returned
// PIPE_LAT cycles later into a per-candidate SAD and tracks the strict minimum.
// The best offset is published with a one-cycle done pulse.
//
// Ports
//   Clk       in   clock, all state on rising edge
//   Rst       in   asynchronous active-high reset
//   start     in   single-cycle request, honoured only in IDLE
//   rd_en     out  row read strobe to the frame/window row buffers
//   cand_x    out  candidate x of the current issue
//   cand_y    out  candidate y of the current issue
//   row_idx   out  block row of the current issue
//   row_sad   in   per-row SAD, valid PIPE_LAT cycles after rd_en
//   busy      out  high from the cycle after start through the done cycle
//   done      out  one-cycle pulse, best_* valid
//   best_sad  out  minimum candidate SAD of the last completed search
//   best_x    out  x of that minimum
//   best_y    out  y of that minimum
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, counters at 0
// ISSUE | one rd_en per cycle, walking row/x/y
// DRAIN | no new issues, waiting for outstanding row_sad returns
// DONE  | best_* published, done pulse, back to IDLE

module sad_search_ctrl #(
  parameter int BLK_ROWS = 16,
  parameter int NUM_X    = 49,
  parameter int NUM_Y    = 33,
  parameter int ROW_W    = 18,
  parameter int ACC_W    = 22,
  parameter int PIPE_LAT = 2,
  localparam int XW = (NUM_X    > 1) ? $clog2(NUM_X)    : 1,
  localparam int YW = (NUM_Y    > 1) ? $clog2(NUM_Y)    : 1,
  localparam int RW = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  output logic             rd_en,
  output logic [XW-1:0]    cand_x,
  output logic [YW-1:0]    cand_y,
  output logic [RW-1:0]    row_idx,
  input  logic [ROW_W-1:0] row_sad,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] best_sad,
  output logic [XW-1:0]    best_x,
  output logic [YW-1:0]    best_y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [RW-1:0] ROW_MAX = RW'(BLK_ROWS - 1);
  localparam logic [XW-1:0] X_MAX   = XW'(NUM_X - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(NUM_Y - 1);
  localparam int            LAST    = PIPE_LAT - 1;

  state_t state_q, state_d;

  logic [RW-1:0]    row_q, row_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] run_sad_q, run_sad_d;
  logic [XW-1:0]    run_x_q, run_x_d;
  logic [YW-1:0]    run_y_q, run_y_d;
  logic [ACC_W-1:0] best_sad_q, best_sad_d;
  logic [XW-1:0]    best_x_q, best_x_d;
  logic [YW-1:0]    best_y_q, best_y_d;

  // Return-tracking pipe: stage 0 is the issue of the previous cycle, stage
  // LAST lines up with the row_sad currently on the input.
  logic [PIPE_LAT-1:0] pv_q, pv_d;
  logic [PIPE_LAT-1:0] pfirst_q, pfirst_d;
  logic [PIPE_LAT-1:0] plast_q, plast_d;
  logic [XW-1:0]       px_q [PIPE_LAT];
  logic [XW-1:0]       px_d [PIPE_LAT];
  logic [YW-1:0]       py_q [PIPE_LAT];
  logic [YW-1:0]       py_d [PIPE_LAT];

  logic             last_issue;
  logic             pend_upstream;
  logic [ACC_W-1:0] ret_sum;

  assign rd_en    = (state_q == S_ISSUE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign cand_x   = x_q;
  assign cand_y   = y_q;
  assign row_idx  = row_q;
  assign best_sad = best_sad_q;
  assign best_x   = best_x_q;
  assign best_y   = best_y_q;

  assign last_issue = (row_q == ROW_MAX) && (x_q == X_MAX) && (y_q == Y_MAX);

  // A first row restarts the sum, so the accumulator never needs clearing
  // between candidates or after an aborted search.
  assign ret_sum = pfirst_q[LAST] ? ACC_W'(row_sad) : (acc_q + ACC_W'(row_sad));

  // Anything still in flight other than the return being consumed right now.
  always_comb begin
    pend_upstream = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      pend_upstream = pend_upstream | pv_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    run_sad_d  = run_sad_q;
    run_x_d    = run_x_q;
    run_y_d    = run_y_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    pv_d       = pv_q;
    pfirst_d   = pfirst_q;
    plast_d    = plast_q;
    px_d       = px_q;
    py_d       = py_q;

    pv_d[0]     = rd_en;
    pfirst_d[0] = (row_q == '0);
    plast_d[0]  = (row_q == ROW_MAX);
    px_d[0]     = x_q;
    py_d[0]     = y_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pv_d[i]     = pv_q[i-1];
      pfirst_d[i] = pfirst_q[i-1];
      plast_d[i]  = plast_q[i-1];
      px_d[i]     = px_q[i-1];
      py_d[i]     = py_q[i-1];
    end

    // Strict less-than keeps the earliest candidate in scan order on ties.
    if (pv_q[LAST]) begin
      acc_d = ret_sum;
      if (plast_q[LAST] && (ret_sum < run_sad_q)) begin
        run_sad_d = ret_sum;
        run_x_d   = px_q[LAST];
        run_y_d   = py_q[LAST];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          row_d     = '0;
          x_d       = '0;
          y_d       = '0;
          run_sad_d = '1;
          run_x_d   = '0;
          run_y_d   = '0;
        end
      end
      S_ISSUE: begin
        if (row_q == ROW_MAX) begin
          row_d = '0;
          if (x_q == X_MAX) begin
            x_d = '0;
            y_d = (y_q == Y_MAX) ? '0 : (y_q + YW'(1));
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          row_d = row_q + RW'(1);
        end
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The final return is consumed on this same edge, so publish the
        // running values including that last compare.
        if (!pend_upstream) begin
          state_d    = S_DONE;
          best_sad_d = run_sad_d;
          best_x_d   = run_x_d;
          best_y_d   = run_y_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      row_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      run_sad_q  <= '0;
      run_x_q    <= '0;
      run_y_q    <= '0;
      best_sad_q <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      pv_q       <= '0;
      pfirst_q   <= '0;
      plast_q    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      row_q      <= row_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      run_sad_q  <= run_sad_d;
      run_x_q    <= run_x_d;
      run_y_q    <= run_y_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      pv_q       <= pv_d;
      pfirst_q   <= pfirst_d;
      plast_q    <= plast_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        px_q[i] <= px_d[i];
        py_q[i] <= py_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl with a small search window (3x2 candidates, 4 rows).
// A row-buffer model answers every rd_en with a table value PIPE_LAT cycles
// later and drives random garbage otherwise. Expected results come from a
// direct minimum search over the table in scan order.

module tb_sad_search_ctrl;

  localparam int BR       = 4;
  localparam int NX       = 3;
  localparam int NY       = 2;
  localparam int ROW_W    = 18;
  localparam int ACC_W    = 22;
  localparam int PL       = 2;
  localparam int N        = NX * NY * BR;
  localparam int DONE_CYC = N + PL + 1;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             start = 1'b0;
  logic             rd_en;
  logic [1:0]       cand_x;
  logic [0:0]       cand_y;
  logic [1:0]       row_idx;
  logic [ROW_W-1:0] row_sad = '0;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] best_sad;
  logic [1:0]       best_x;
  logic [0:0]       best_y;

  sad_search_ctrl #(
    .BLK_ROWS(BR), .NUM_X(NX), .NUM_Y(NY),
    .ROW_W(ROW_W), .ACC_W(ACC_W), .PIPE_LAT(PL)
  ) dut (
    .Clk(Clk), .Rst(Rst), .start(start),
    .rd_en(rd_en), .cand_x(cand_x), .cand_y(cand_y), .row_idx(row_idx),
    .row_sad(row_sad), .busy(busy), .done(done),
    .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ROW_W-1:0] tbl [NY][NX][BR];
  longint exp_sad, prev_sad;
  int     exp_x, exp_y, prev_x, prev_y;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Row-buffer model, evaluated on the falling edge: slot j holds the issue
  // made j cycles ago, so slot PL answers the issue made PL cycles earlier.
  typedef struct {
    bit v;
    int x;
    int y;
    int r;
  } iss_t;
  iss_t dl [PL+1];

  always @(negedge Clk) begin
    if (Rst) begin
      for (int i = 0; i <= PL; i++) dl[i].v = 1'b0;
      row_sad = ROW_W'($urandom);
    end else begin
      for (int i = PL; i > 0; i--) dl[i] = dl[i-1];
      dl[0].v = rd_en;
      dl[0].x = int'(cand_x);
      dl[0].y = int'(cand_y);
      dl[0].r = int'(row_idx);
      if (dl[PL].v && dl[PL].x < NX && dl[PL].y < NY && dl[PL].r < BR)
        row_sad = tbl[dl[PL].y][dl[PL].x][dl[PL].r];
      else
        row_sad = ROW_W'($urandom);
    end
  end

  // 0: random full scale, 1: random tiny (many ties), 2: unique minimum,
  // 3: full-scale rows with two tied minima.
  task automatic fill(input int mode);
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++)
        for (int r = 0; r < BR; r++) begin
          case (mode)
            0:       tbl[y][x][r] = ROW_W'($urandom);
            1:       tbl[y][x][r] = ROW_W'($urandom_range(0, 3));
            2:       tbl[y][x][r] = ROW_W'(10);
            default: tbl[y][x][r] = '1;
          endcase
        end
    if (mode == 2) begin
      for (int r = 0; r < BR; r++) tbl[0][2][r] = ROW_W'(r + 1);
    end
    if (mode == 3) begin
      tbl[0][1][0] = 1; tbl[0][1][1] = 2; tbl[0][1][2] = 3; tbl[0][1][3] = 1;
      tbl[1][0][0] = 0; tbl[1][0][1] = 0; tbl[1][0][2] = 0; tbl[1][0][3] = 7;
    end
  endtask

  task automatic model();
    longint s;
    exp_sad = (64'd1 << ACC_W) - 1;
    exp_x = 0;
    exp_y = 0;
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++) begin
        s = 0;
        for (int r = 0; r < BR; r++) s += longint'(tbl[y][x][r]);
        if (s < exp_sad) begin
          exp_sad = s;
          exp_x = x;
          exp_y = y;
        end
      end
  endtask

  // Starts a search right after a falling edge; start_at pulses start again
  // mid-search, rst_at asserts reset in that cycle and abandons the search.
  task automatic run_search(input string name, input int start_at, input int rst_at);
    bit aborted;
    int i;
    aborted = 1'b0;
    model();
    start = 1'b1;
    for (int cyc = 1; cyc <= DONE_CYC + 1 && !aborted; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) start = 1'b0;
      chk({name, " rd_en"}, rd_en, (cyc <= N));
      chk({name, " busy"},  busy,  (cyc <= DONE_CYC));
      chk({name, " done"},  done,  (cyc == DONE_CYC));
      if (cyc <= N) begin
        i = cyc - 1;
        chk({name, " cand_x"},  cand_x,  (i / BR) % NX);
        chk({name, " cand_y"},  cand_y,  i / (BR * NX));
        chk({name, " row_idx"}, row_idx, i % BR);
      end else if (cyc == DONE_CYC + 1) begin
        chk({name, " idle cand"}, {cand_x, cand_y, row_idx}, 0);
      end
      if (cyc < DONE_CYC) begin
        chk({name, " held best_sad"}, best_sad, prev_sad);
        chk({name, " held best_xy"},  {best_x, best_y}, {prev_x[1:0], prev_y[0]});
      end else begin
        chk({name, " best_sad"}, best_sad, exp_sad);
        chk({name, " best_x"},   best_x,   exp_x);
        chk({name, " best_y"},   best_y,   exp_y);
      end
      if (cyc == start_at)     start = 1'b1;
      if (cyc == start_at + 1) start = 1'b0;
      if (cyc == rst_at) begin
        Rst = 1'b1;
        #1;
        chk({name, " rst rd_en/busy/done"}, {rd_en, busy, done}, 0);
        chk({name, " rst cand"}, {cand_x, cand_y, row_idx}, 0);
        chk({name, " rst best_sad"}, best_sad, 0);
        chk({name, " rst best_xy"}, {best_x, best_y}, 0);
        @(negedge Clk);
        Rst = 1'b0;
        prev_sad = 0;
        prev_x = 0;
        prev_y = 0;
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      prev_sad = exp_sad;
      prev_x = exp_x;
      prev_y = exp_y;
    end
  endtask

  initial begin
    prev_sad = 0;
    prev_x = 0;
    prev_y = 0;
    for (int i = 0; i <= PL; i++) dl[i].v = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      chk("idle rd_en/busy/done", {rd_en, busy, done}, 0);
      chk("idle best_sad", best_sad, 0);
      chk("idle best_xy", {best_x, best_y}, 0);
    end

    fill(2); run_search("unique", 0, 0);
    fill(3); run_search("tie_max", 0, 0);
    fill(0); run_search("busy_start", 10, 0);
    fill(1); run_search("back2back", 0, 0);
    fill(0); run_search("rst_mid", 0, 12);
    fill(0); run_search("after_rst", 0, 0);
    for (int k = 0; k < 6; k++) begin
      fill(int'($urandom_range(0, 1)));
      run_search("random", 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
